// File: rtl/bridge_pkg.sv
// Shared types and ASCII constants for the UART-to-bus request parser.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_EOL  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder; accepts 0-9, A-F and a-f.
module hex_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_hex
);

  logic [7:0] diff_s;

  // Map the ASCII code onto its nibble value and flag whether it is a hex digit
  always_comb begin
    diff_s = 8'h00;
    nibble = 4'h0;
    is_hex = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      diff_s = ascii - 8'h30;
      is_hex = 1'b1;
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      diff_s = ascii - 8'h37;
      is_hex = 1'b1;
    end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
      diff_s = ascii - 8'h57;
      is_hex = 1'b1;
    end else begin
      diff_s = 8'h00;
      is_hex = 1'b0;
    end
    nibble = diff_s[3:0];
  end

endmodule

// File: rtl/bridge_rx.sv
// Parses "R<addr>\r" / "W<addr><data>\r" ASCII requests into single-cycle bus strobes.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  output logic                  valid_o
);

  localparam int ADDR_DIG = ADDR_WIDTH / 4;
  localparam int DATA_DIG = DATA_WIDTH / 4;
  localparam int MAX_DIG  = (ADDR_DIG > DATA_DIG) ? ADDR_DIG : DATA_DIG;
  localparam int CNT_W    = $clog2(MAX_DIG + 1);

  state_t                state_r;
  logic                  is_write_r;
  logic [ADDR_WIDTH-1:0] addr_sh_r;
  logic [DATA_WIDTH-1:0] data_sh_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [3:0]            nibble_s;
  logic                  is_hex_s;

  hex_decode u_hex_decode (
    .ascii  (rx_data_i),
    .nibble (nibble_s),
    .is_hex (is_hex_s)
  );

  // Request parser FSM; any grammar violation drops back to IDLE without issuing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      is_write_r <= 1'b0;
      addr_sh_r  <= '0;
      data_sh_r  <= '0;
      cnt_r      <= '0;
      addr_o     <= '0;
      wdata_o    <= '0;
      rw_o       <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (rx_valid_i) begin
        case (state_r)
          ST_IDLE: begin
            cnt_r     <= '0;
            addr_sh_r <= '0;
            data_sh_r <= '0;
            if (rx_data_i == ASCII_R) begin
              is_write_r <= 1'b0;
              state_r    <= ST_ADDR;
            end else if (rx_data_i == ASCII_W) begin
              is_write_r <= 1'b1;
              state_r    <= ST_ADDR;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            if (is_hex_s) begin
              addr_sh_r <= (addr_sh_r << 4) | ADDR_WIDTH'(nibble_s);
              if (cnt_r == CNT_W'(ADDR_DIG - 1)) begin
                cnt_r   <= '0;
                state_r <= is_write_r ? ST_DATA : ST_EOL;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else begin
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            if (is_hex_s) begin
              data_sh_r <= (data_sh_r << 4) | DATA_WIDTH'(nibble_s);
              if (cnt_r == CNT_W'(DATA_DIG - 1)) begin
                cnt_r   <= '0;
                state_r <= ST_EOL;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else begin
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end
          ST_EOL: begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
            if (is_term(rx_data_i)) begin
              valid_o <= 1'b1;
              addr_o  <= addr_sh_r;
              wdata_o <= is_write_r ? data_sh_r : '0;
              rw_o    <= is_write_r;
            end
          end
          default: begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bridge_rx.md
BRIDGE_RX -- requirements
Module: bridge_rx

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: bus address width; SHALL be a multiple of 4.
REQ-002 Parameter DATA_WIDTH, default 16: bus data width; SHALL be a multiple of 4.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 rx_data_i  input  8  received ASCII byte from the UART receiver.
REQ-006 rx_valid_i  input  1  rx_data_i is valid this cycle; one byte per cycle maximum.
REQ-007 addr_o  output  ADDR_WIDTH  bus address to the first core in the chain.
REQ-008 wdata_o  output  DATA_WIDTH  bus write data.
REQ-009 rw_o  output  1  1 = write, 0 = read.
REQ-010 valid_o  output  1  single-cycle strobe qualifying addr_o, wdata_o and rw_o.

Function
REQ-011 Read request grammar: 'R', then ADDR_WIDTH/4 hex digits (MSB first), then a terminator.
REQ-012 Write request grammar: 'W', then ADDR_WIDTH/4 address digits, then DATA_WIDTH/4 data digits, then a terminator.
REQ-013 Terminator: CR (0x0D) or LF (0x0A).
REQ-014 Hex digits: 0-9, A-F and a-f are accepted; 'R' and 'W' are uppercase only.
REQ-015 FSM states: IDLE, ADDR, DATA, EOL.
REQ-016 FSM transitions:
  - IDLE: 'R' or 'W' -> ADDR, latching the request type.
  - ADDR, after the last address digit: read -> EOL; write -> DATA.
  - DATA, after the last data digit -> EOL.
  - EOL, on a terminator -> IDLE and issue the transaction.
REQ-017 Bytes SHALL be consumed only in cycles where rx_valid_i=1; cycles with rx_valid_i=0 SHALL leave state and counters unchanged, with no timeout.
REQ-018 Each accepted digit SHALL be shifted into the address or data shift register, and the digit counter SHALL increment.
REQ-019 Error handling (no transaction issued, state -> IDLE, counters cleared):
  - non-hex byte in ADDR or DATA;
  - terminator arriving before the digit count completes;
  - any non-terminator byte in EOL, including a surplus digit.
REQ-020 In IDLE, any byte other than 'R' or 'W' SHALL be ignored, so stray CR/LF between requests is harmless.
REQ-021 valid_o SHALL assert for exactly one cycle, the cycle after the terminator byte is sampled.
REQ-022 addr_o, wdata_o and rw_o SHALL be valid during the valid_o cycle and SHALL hold until the next transaction.
REQ-023 A read request SHALL drive wdata_o = 0.
REQ-024 There is no backpressure: back-to-back requests with rx_valid_i=1 every cycle SHALL each produce one valid_o pulse, in order.
REQ-025 An 'R' or 'W' received in a non-IDLE state SHALL be treated as an error per REQ-019 and SHALL NOT start a new request.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 asynchronously, the FSM SHALL be in IDLE, and the shift registers and counters SHALL be 0.
REQ-027 Reset asserted mid-request SHALL discard the partial request; no valid_o SHALL be issued for it after release.
REQ-028 The first byte sampled after rst_n rises SHALL be parsed from IDLE.

Structure
REQ-029 A shared package bridge_pkg SHALL hold:
  - the FSM state enum;
  - the ASCII constants 'R', 'W', CR and LF.
REQ-030 One sub-module, hex_decode, SHALL convert an 8-bit ASCII byte to a 4-bit nibble plus an is_hex flag, purely combinationally.
REQ-031 All registered state SHALL reside in bridge_rx.

Verification
REQ-032 Bytes "R0003\r" -> exactly one valid_o pulse, one cycle after CR, with addr_o=0x0003, rw_o=0, wdata_o=0x0000.
REQ-033 Bytes "W0001FFBB\n" -> one pulse with addr_o=0x0001, wdata_o=0xFFBB, rw_o=1; also repeat with lowercase "w0001ffbb\n" -> no pulse ('w' ignored in IDLE).
REQ-034 Bytes "R00G1\r", then "R12\r", then "W00010002X\r" -> no valid_o pulse at any point; a following "R0002\r" yields addr_o=0x0002.
REQ-035 Bytes "R0001\rW00020005\r" streamed with rx_valid_i=1 every cycle -> two pulses, read of 0x0001 then write of 0x0005 to 0x0002.
REQ-036 Bytes "W00" then rst_n low for 2 cycles, then "0005\r" -> no pulse; then "R0000\r" -> pulse with addr_o=0x0000, rw_o=0.
REQ-037 Bytes "R0001\r" with rx_valid_i toggled 1/0 on alternate cycles -> same single pulse as REQ-032 with addr_o=0x0001.
